// File: rtl/zapper_ctrl.sv
// zapper_ctrl: light-gun shot sequencer.
// A debounced trigger press starts a shot. The shot shows one all-black frame and then
// one target-only frame, and it measures the photodiode during each. It scores a hit
// only when the gun saw light on the target frame and no light on the black frame.
// The block also tracks the shots left and the hits for the current round.
module zapper_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int MIN_LIGHT_PIX   = 64,
   parameter int SHOTS_PER_ROUND = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       trigger,
   input  logic       sensor,
   input  logic       frame_start,
   input  logic       valid,
   input  logic       game_enable,
   input  logic       round_start,
   output logic       show_black,
   output logic       show_target,
   output logic       busy,
   output logic       hit,
   output logic       miss,
   output logic [2:0] shots_left,
   output logic [7:0] hit_count
);

   localparam int            DB_W       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0]   MIN_PIX    = 16'(MIN_LIGHT_PIX);
   localparam logic [2:0]    SHOTS_INIT = 3'(SHOTS_PER_ROUND);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARM_WAIT = 3'd1,
      BLACK    = 3'd2,
      TARGET   = 3'd3,
      RESULT   = 3'd4,
      COOLDOWN = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_nextState;

   logic              r_trigMeta;
   logic              r_trigSync;
   logic              r_sensMeta;
   logic              r_sensSync;

   logic [DB_W-1:0]   r_dbCnt;
   logic              r_dbTrig;
   logic              r_dbTrigPrev;
   logic              w_shotReq;

   logic [15:0]       r_lightCnt;
   logic [15:0]       r_blackCnt;
   logic              w_lightInc;
   logic [15:0]       w_lightSum;
   logic              w_enterBlack;
   logic              w_enterTarget;
   logic              w_enterResult;
   logic              w_isHit;

   logic              r_showBlack;
   logic              r_showTarget;
   logic              r_busy;
   logic              r_hit;
   logic              r_miss;
   logic [2:0]        r_shotsLeft;
   logic [7:0]        r_hitCount;

   // Two-flop synchronizers for the asynchronous trigger and photodiode inputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_trigMeta <= 1'b0;
         r_trigSync <= 1'b0;
         r_sensMeta <= 1'b0;
         r_sensSync <= 1'b0;
      end else begin
         r_trigMeta <= trigger;
         r_trigSync <= r_trigMeta;
         r_sensMeta <= sensor;
         r_sensSync <= r_sensMeta;
      end
   end

   // The debounced level flips only after the synced trigger has held the new level for
   // DEBOUNCE_CYCLES cycles in a row. Any cycle back at the old level restarts the count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dbCnt      <= '0;
         r_dbTrig     <= 1'b0;
         r_dbTrigPrev <= 1'b0;
      end else begin
         r_dbTrigPrev <= r_dbTrig;
         if (r_trigSync != r_dbTrig) begin
            if (r_dbCnt == DB_LAST) begin
               r_dbTrig <= r_trigSync;
               r_dbCnt  <= '0;
            end else begin
               r_dbCnt <= r_dbCnt + DB_W'(1);
            end
         end else begin
            r_dbCnt <= '0;
         end
      end
   end

   assign w_shotReq = r_dbTrig & ~r_dbTrigPrev;

   // State register for the shot sequencer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. round_start overrides everything, and a disabled game aborts a
   // shot only before the result is decided.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_shotReq && game_enable && (r_shotsLeft != 3'd0)) begin
               w_nextState = ARM_WAIT;
            end
         end
         ARM_WAIT: begin
            if (!game_enable) begin
               w_nextState = IDLE;
            end else if (frame_start) begin
               w_nextState = BLACK;
            end
         end
         BLACK: begin
            if (!game_enable) begin
               w_nextState = IDLE;
            end else if (frame_start) begin
               w_nextState = TARGET;
            end
         end
         TARGET: begin
            if (!game_enable) begin
               w_nextState = IDLE;
            end else if (frame_start) begin
               w_nextState = RESULT;
            end
         end
         RESULT: begin
            w_nextState = COOLDOWN;
         end
         COOLDOWN: begin
            if (!r_dbTrig) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
      if (round_start) begin
         w_nextState = IDLE;
      end
   end

   assign w_enterBlack  = (r_state != BLACK)  && (w_nextState == BLACK);
   assign w_enterTarget = (r_state != TARGET) && (w_nextState == TARGET);
   assign w_enterResult = (r_state != RESULT) && (w_nextState == RESULT);

   // The running light count includes the current cycle. That way the frame_start cycle
   // that closes a frame still counts toward the frame it ends.
   assign w_lightInc = valid & r_sensSync & (r_lightCnt != 16'hFFFF);
   assign w_lightSum = r_lightCnt + {15'd0, w_lightInc};
   assign w_isHit    = (w_lightSum >= MIN_PIX) && (r_blackCnt < MIN_PIX);

   // Saturating light counter, cleared at the start of each measured frame. The black
   // frame total is latched when the target frame begins. After TARGET ends, the running
   // counter itself holds the target frame total.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lightCnt <= 16'd0;
         r_blackCnt <= 16'd0;
      end else begin
         if (w_enterBlack || w_enterTarget) begin
            r_lightCnt <= 16'd0;
         end else begin
            r_lightCnt <= w_lightSum;
         end
         if (w_enterTarget) begin
            r_blackCnt <= w_lightSum;
         end
      end
   end

   // Registered display commands, busy flag and verdict pulses. They are all decoded
   // from the next state, so they line up exactly with the state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_showBlack  <= 1'b0;
         r_showTarget <= 1'b0;
         r_busy       <= 1'b0;
         r_hit        <= 1'b0;
         r_miss       <= 1'b0;
      end else begin
         r_showBlack  <= (w_nextState == BLACK);
         r_showTarget <= (w_nextState == TARGET);
         r_busy       <= (w_nextState != IDLE);
         r_hit        <= w_enterResult && w_isHit;
         r_miss       <= w_enterResult && !w_isHit;
      end
   end

   // Round bookkeeping. A completed shot is charged at the end of its RESULT cycle, and a
   // coincident round_start wins so that the round simply reloads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shotsLeft <= SHOTS_INIT;
         r_hitCount  <= 8'd0;
      end else if (round_start) begin
         r_shotsLeft <= SHOTS_INIT;
         r_hitCount  <= 8'd0;
      end else if (r_state == RESULT) begin
         if (r_shotsLeft != 3'd0) begin
            r_shotsLeft <= r_shotsLeft - 3'd1;
         end
         if (r_hit && (r_hitCount != 8'hFF)) begin
            r_hitCount <= r_hitCount + 8'd1;
         end
      end
   end

   assign show_black  = r_showBlack;
   assign show_target = r_showTarget;
   assign busy        = r_busy;
   assign hit         = r_hit;
   assign miss        = r_miss;
   assign shots_left  = r_shotsLeft;
   assign hit_count   = r_hitCount;

endmodule
